// File: rtl/tlb_mp.sv
// rtl/tlb_mp.sv - multi-port MIPS32 joint TLB with probe, read, write and Random/Wired
//
// Purpose: NPORTS registered VA->PA translation ports sharing one ENTRIES-deep
//   joint TLB. Also provides a registered TLBP probe, a combinational TLBR read
//   and TLBWI/TLBWR writes. Holds the CP0 Random and Wired registers.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   asid                          current EntryHi.ASID (lookups and probe)
//   lk_req/lk_vaddr               per-port lookup request and virtual address
//   lk_ack/lk_paddr/lk_miss/
//   lk_valid/lk_dirty/lk_uncached per-port registered lookup result
//   tlb_we/tlb_wr_random/
//   tlb_config_index/tlb_config   entry write (TLBWI/TLBWR); tlb_config VPN2 is the probe key
//   wired_we/wired_i/random_o     Wired write, current Random
//   tlb_p/tlb_p_done/tlb_p_res_o  probe request and registered result
//   tlb_read_index/
//   tlb_read_config_o             TLBR read port
module tlb_mp #(
  parameter int ENTRIES = 16,
  parameter int NPORTS  = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            asid,
  input  logic [NPORTS-1:0]     lk_req,
  input  logic [NPORTS*32-1:0]  lk_vaddr,
  output logic [NPORTS-1:0]     lk_ack,
  output logic [NPORTS*32-1:0]  lk_paddr,
  output logic [NPORTS-1:0]     lk_miss,
  output logic [NPORTS-1:0]     lk_valid,
  output logic [NPORTS-1:0]     lk_dirty,
  output logic [NPORTS-1:0]     lk_uncached,
  input  logic                  tlb_we,
  input  logic                  tlb_wr_random,
  input  logic [IDX_W-1:0]      tlb_config_index,
  input  logic [85:0]           tlb_config,
  input  logic                  wired_we,
  input  logic [IDX_W-1:0]      wired_i,
  output logic [IDX_W-1:0]      random_o,
  input  logic                  tlb_p,
  output logic                  tlb_p_done,
  output logic [31:0]           tlb_p_res_o,
  input  logic [IDX_W-1:0]      tlb_read_index,
  output logic [85:0]           tlb_read_config_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [85:0]      tlb [ENTRIES];
  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] wired_q;
  logic [IDX_W-1:0] wr_idx;

  assign random_o          = random_q;
  assign tlb_read_config_o = tlb[tlb_read_index];
  assign wr_idx            = tlb_wr_random ? random_q : tlb_config_index;

  // Entry storage. Lookups and probes in the write cycle read the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tlb[i] <= '0;
    end else if (tlb_we) begin
      tlb[wr_idx] <= tlb_config;
    end
  end

  // Random walks down from ENTRIES-1 to Wired, then wraps back to ENTRIES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      wired_q  <= '0;
      random_q <= LAST_IDX;
    end else if (wired_we) begin
      wired_q  <= wired_i;
      random_q <= LAST_IDX;
    end else if (random_q == wired_q) begin
      random_q <= LAST_IDX;
    end else begin
      random_q <= random_q - IDX_W'(1);
    end
  end

  // Translation ports.
  genvar gp;
  for (gp = 0; gp < NPORTS; gp++) begin : g_port
    logic [31:0]      va;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [19:0]      pfn;
    logic [2:0]       cca;
    logic             d_bit;
    logic             v_bit;
    logic             ack_q, miss_q, valid_q, dirty_q, unc_q;
    logic [31:0]      paddr_q;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
      va  = lk_vaddr[32*gp +: 32];
      hit = 1'b0;
      idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (tlb[i][70:52] == va[31:13] && (tlb[i][51] || tlb[i][85:78] == asid)) begin
          hit = 1'b1;
          idx = i[IDX_W-1:0];
        end
      end
      pfn   = va[12] ? tlb[idx][25:6] : tlb[idx][50:31];
      cca   = va[12] ? tlb[idx][5:3]  : tlb[idx][30:28];
      d_bit = va[12] ? tlb[idx][2]    : tlb[idx][27];
      v_bit = va[12] ? tlb[idx][1]    : tlb[idx][26];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ack_q   <= 1'b0;
        paddr_q <= '0;
        miss_q  <= 1'b0;
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
        unc_q   <= 1'b0;
      end else begin
        ack_q <= lk_req[gp];
        if (lk_req[gp]) begin
          paddr_q <= hit ? {pfn, va[11:0]} : 32'd0;
          miss_q  <= ~hit;
          valid_q <= hit & v_bit;
          dirty_q <= hit & d_bit;
          unc_q   <= hit & (cca == 3'd2);
        end
      end
    end

    assign lk_ack[gp]             = ack_q;
    assign lk_paddr[32*gp +: 32]  = paddr_q;
    assign lk_miss[gp]            = miss_q;
    assign lk_valid[gp]           = valid_q;
    assign lk_dirty[gp]           = dirty_q;
    assign lk_uncached[gp]        = unc_q;
  end

  // Probe: key is the VPN2 field of tlb_config, matched against the asid input.
  logic             p_hit;
  logic [IDX_W-1:0] p_idx;

  always_comb begin
    p_hit = 1'b0;
    p_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tlb[i][70:52] == tlb_config[70:52] && (tlb[i][51] || tlb[i][85:78] == asid)) begin
        p_hit = 1'b1;
        p_idx = i[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tlb_p_done  <= 1'b0;
      tlb_p_res_o <= '0;
    end else begin
      tlb_p_done <= tlb_p;
      if (tlb_p) begin
        tlb_p_res_o <= p_hit ? {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;
      end
    end
  end

endmodule

// File: tb/tb_tlb_mp.sv
// tb/tb_tlb_mp.sv - scoreboard testbench for tlb_mp
module tb_tlb_mp;
  localparam int ENTRIES = 16;
  localparam int NPORTS  = 2;
  localparam int IDX_W   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           asid;
  logic [NPORTS-1:0]    lk_req;
  logic [NPORTS*32-1:0] lk_vaddr;
  logic [NPORTS-1:0]    lk_ack;
  logic [NPORTS*32-1:0] lk_paddr;
  logic [NPORTS-1:0]    lk_miss, lk_valid, lk_dirty, lk_uncached;
  logic                 tlb_we, tlb_wr_random;
  logic [IDX_W-1:0]     tlb_config_index;
  logic [85:0]          tlb_config;
  logic                 wired_we;
  logic [IDX_W-1:0]     wired_i;
  logic [IDX_W-1:0]     random_o;
  logic                 tlb_p, tlb_p_done;
  logic [31:0]          tlb_p_res_o;
  logic [IDX_W-1:0]     tlb_read_index;
  logic [85:0]          tlb_read_config_o;

  always #5 clk = ~clk;

  tlb_mp #(.ENTRIES(ENTRIES), .NPORTS(NPORTS)) dut (
    .clk(clk), .rst(rst), .asid(asid),
    .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_ack(lk_ack), .lk_paddr(lk_paddr),
    .lk_miss(lk_miss), .lk_valid(lk_valid), .lk_dirty(lk_dirty), .lk_uncached(lk_uncached),
    .tlb_we(tlb_we), .tlb_wr_random(tlb_wr_random), .tlb_config_index(tlb_config_index),
    .tlb_config(tlb_config), .wired_we(wired_we), .wired_i(wired_i), .random_o(random_o),
    .tlb_p(tlb_p), .tlb_p_done(tlb_p_done), .tlb_p_res_o(tlb_p_res_o),
    .tlb_read_index(tlb_read_index), .tlb_read_config_o(tlb_read_config_o)
  );

  typedef struct {
    int          port;
    logic        miss;
    logic [31:0] paddr;
    logic        valid;
    logic        dirty;
    logic        unc;
  } exp_t;

  exp_t        exp_q[$];
  logic [85:0] m_tlb [ENTRIES];
  logic        pend_we;
  int          pend_idx;
  logic [85:0] pend_cfg;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic chk(input string tag, input logic [85:0] got, input logic [85:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [85:0] mk(input logic [7:0] a, input logic [18:0] vpn2, input logic g,
                                     input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                                     input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    return {a, 7'd0, vpn2, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1, 1'b0};
  endfunction

  function automatic exp_t model(input int p, input logic [31:0] va, input logic [7:0] a);
    exp_t r;
    r.port = p; r.miss = 1'b1; r.paddr = '0; r.valid = 1'b0; r.dirty = 1'b0; r.unc = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_tlb[i][70:52] == va[31:13] && (m_tlb[i][51] || m_tlb[i][85:78] == a)) begin
        r.miss = 1'b0;
        if (va[12]) begin
          r.paddr = {m_tlb[i][25:6], va[11:0]};
          r.unc = (m_tlb[i][5:3] == 3'd2); r.dirty = m_tlb[i][2]; r.valid = m_tlb[i][1];
        end else begin
          r.paddr = {m_tlb[i][50:31], va[11:0]};
          r.unc = (m_tlb[i][30:28] == 3'd2); r.dirty = m_tlb[i][27]; r.valid = m_tlb[i][26];
        end
        break;
      end
    end
    return r;
  endfunction

  // Scoreboard consumer: every ack pops the oldest expectation.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    for (int p = 0; p < NPORTS; p++) begin
      if (lk_ack[p] === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ack", 86'(p + 1), 86'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_port", 86'(p), 86'(e.port));
          chk("sb_miss", 86'(lk_miss[p]), 86'(e.miss));
          if (!e.miss) begin
            chk("sb_paddr", 86'(lk_paddr[32*p +: 32]), 86'(e.paddr));
            chk("sb_valid", 86'(lk_valid[p]), 86'(e.valid));
            chk("sb_dirty", 86'(lk_dirty[p]), 86'(e.dirty));
            chk("sb_uncached", 86'(lk_uncached[p]), 86'(e.unc));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_tlb[i] = '0;
    end else if (pend_we) begin
      m_tlb[pend_idx] = pend_cfg;
    end
    pend_we = 1'b0;
    #1;
    lk_req = '0; tlb_we = 1'b0; tlb_wr_random = 1'b0; wired_we = 1'b0; tlb_p = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [85:0] cfg);
    tlb_we = 1'b1; tlb_wr_random = 1'b0; tlb_config_index = IDX_W'(idx); tlb_config = cfg;
    pend_we = 1'b1; pend_idx = idx; pend_cfg = cfg;
  endtask

  task automatic issue(input int p, input logic [31:0] va);
    lk_req[p] = 1'b1;
    lk_vaddr[32*p +: 32] = va;
    exp_q.push_back(model(p, va, asid));
  endtask

  task automatic probe(input logic [18:0] vpn2);
    tlb_config = mk(8'd0, vpn2, 1'b0, 20'd0, 3'd0, 1'b0, 1'b0, 20'd0, 3'd0, 1'b0, 1'b0);
    tlb_p = 1'b1;
  endtask

  logic [85:0] e3, e2, er;

  initial begin
    rst = 1'b1; asid = 8'd0; lk_req = '0; lk_vaddr = '0; tlb_we = 1'b0; tlb_wr_random = 1'b0;
    tlb_config_index = '0; tlb_config = '0; wired_we = 1'b0; wired_i = '0; tlb_p = 1'b0;
    tlb_read_index = '0; pend_we = 1'b0; pend_idx = 0; pend_cfg = '0;
    tick(); tick();
    chk("rst_ack", 86'(lk_ack), 86'd0);
    chk("rst_paddr", 86'(lk_paddr), 86'd0);
    chk("rst_flags", 86'({lk_miss, lk_valid, lk_dirty, lk_uncached}), 86'd0);
    chk("rst_probe", 86'({tlb_p_done, tlb_p_res_o}), 86'd0);
    chk("rst_random", 86'(random_o), 86'(ENTRIES - 1));
    chk("rst_entry", tlb_read_config_o, 86'd0);
    rst = 1'b0;

    // Random / Wired
    tick();
    chk("rand_dec", 86'(random_o), 86'(ENTRIES - 2));
    wired_we = 1'b1; wired_i = 4'd4;
    tick();
    for (int i = 0; i <= 12; i++) begin
      chk("rand_seq", 86'(random_o), 86'((i <= 11) ? (ENTRIES - 1 - i) : (ENTRIES - 1)));
      tick();
    end
    er = mk(8'd1, 19'h30000, 1'b0, 20'h0CAFE, 3'd3, 1'b1, 1'b1, 20'd0, 3'd0, 1'b0, 1'b0);
    wr(0, er); tlb_wr_random = 1'b1; pend_idx = ENTRIES - 2;
    tick();
    tlb_read_index = 4'd14; #1;
    chk("tlbwr_at_random", tlb_read_config_o, er);
    tlb_read_index = 4'd13; #1;
    chk("tlbwr_not_next", tlb_read_config_o, 86'd0);
    wired_we = 1'b1; wired_i = 4'd15;
    tick(); chk("wired_max0", 86'(random_o), 86'(ENTRIES - 1));
    tick(); chk("wired_max1", 86'(random_o), 86'(ENTRIES - 1));
    wired_we = 1'b1; wired_i = 4'd0;
    tick();

    // Basic translation, ASID and G
    asid = 8'd5;
    e3 = mk(8'd5, 19'h00040, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0ABCD, 3'd2, 1'b0, 1'b1);
    wr(3, e3); tick();
    issue(0, 32'h0008_0ABC); tick();
    chk("t1_paddr", 86'(lk_paddr[31:0]), 86'(32'h1234_5ABC));
    chk("t1_flags", 86'({lk_ack[0], lk_miss[0], lk_valid[0], lk_dirty[0], lk_uncached[0]}), 86'(5'b10110));
    tick();
    chk("hold_ack", 86'(lk_ack[0]), 86'd0);
    chk("hold_paddr", 86'(lk_paddr[31:0]), 86'(32'h1234_5ABC));
    asid = 8'd6;
    issue(0, 32'h0008_0ABC); tick();
    chk("asid_miss", 86'(lk_miss[0]), 86'd1);
    e3[51] = 1'b1;
    wr(3, e3); tick();
    issue(0, 32'h0008_0ABC); tick();
    issue(1, 32'h0008_1ABC); tick();
    chk("page1_paddr", 86'(lk_paddr[63:32]), 86'(32'h0ABC_DABC));
    chk("page1_unc", 86'({lk_uncached[1], lk_dirty[1]}), 86'(2'b10));
    wr(9, mk(8'd6, 19'h00040, 1'b0, 20'h99999, 3'd3, 1'b1, 1'b1, 20'd0, 3'd0, 1'b0, 1'b0)); tick();
    issue(0, 32'h0008_0ABC); tick();
    chk("lowest_idx", 86'(lk_paddr[31:0]), 86'(32'h1234_5ABC));

    // Probe
    asid = 8'd5;
    wr(7, mk(8'd5, 19'h01234, 1'b0, 20'h00777, 3'd3, 1'b1, 1'b1, 20'd0, 3'd0, 1'b0, 1'b0)); tick();
    wr(11, mk(8'd5, 19'h01234, 1'b0, 20'h00888, 3'd3, 1'b1, 1'b1, 20'd0, 3'd0, 1'b0, 1'b0)); tick();
    probe(19'h01234); tick();
    chk("probe_hit", 86'({tlb_p_done, tlb_p_res_o}), 86'({1'b1, 32'h0000_0007}));
    tick();
    chk("probe_hold", 86'({tlb_p_done, tlb_p_res_o}), 86'({1'b0, 32'h0000_0007}));
    probe(19'h07777); tick();
    chk("probe_absent", 86'({tlb_p_done, tlb_p_res_o}), 86'({1'b1, 32'h8000_0000}));
    asid = 8'd6;
    probe(19'h01234); tick();
    chk("probe_asid", 86'(tlb_p_res_o), 86'(32'h8000_0000));
    asid = 8'd5;

    // Write/lookup/probe in the same cycle see old contents
    e2 = mk(8'd5, 19'h00055, 1'b0, 20'h0AAAA, 3'd0, 1'b0, 1'b1, 20'h0BBBB, 3'd2, 1'b1, 1'b1);
    wr(2, e2);
    issue(0, {19'h00055, 13'h0100}); tick();
    chk("nobypass_miss", 86'(lk_miss[0]), 86'd1);
    chk("read_after_wr", tlb_read_config_o, 86'd0);
    tlb_read_index = 4'd2; #1;
    chk("read_new", tlb_read_config_o, e2);
    issue(0, {19'h00055, 13'h0100}); tick();
    chk("next_hit", 86'({lk_miss[0], lk_paddr[31:0]}), 86'({1'b0, 32'h0AAA_A100}));
    wr(5, mk(8'd5, 19'h00066, 1'b0, 20'h00001, 3'd3, 1'b0, 1'b1, 20'd0, 3'd0, 1'b0, 1'b0));
    tlb_p = 1'b1; tick();
    chk("probe_nobypass", 86'(tlb_p_res_o), 86'(32'h8000_0000));
    tlb_p = 1'b1; tick();
    chk("probe_new", 86'(tlb_p_res_o), 86'(32'h0000_0005));

    // All ports in one cycle, then reset with requests pending
    issue(0, 32'h0008_0ABC);
    issue(1, {19'h00055, 1'b1, 12'h234}); tick();
    chk("multi_p0", 86'(lk_paddr[31:0]), 86'(32'h1234_5ABC));
    chk("multi_p1", 86'({lk_uncached[1], lk_paddr[63:32]}), 86'({1'b1, 32'h0BBB_B234}));
    lk_req = '1; tlb_p = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstq_ack", 86'({lk_ack, tlb_p_done}), 86'd0);
    chk("rstq_paddr", 86'(lk_paddr), 86'd0);
    chk("rstq_flags", 86'({lk_miss, lk_valid, lk_dirty, lk_uncached}), 86'd0);
    chk("rstq_pres", 86'(tlb_p_res_o), 86'd0);
    chk("rstq_entry", tlb_read_config_o, 86'd0);
    tick();
    chk("rstq_quiet", 86'(lk_ack), 86'd0);
    chk("sb_empty", 86'(exp_q.size()), 86'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
